// File: rtl/rca_bist_pkg.sv
// rtl/rca_bist_pkg.sv - shared types and width helpers for the RCA self-test block
package rca_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Vector index is {a, b, cin}
  function automatic int vec_w(input int width);
    return 2 * width + 1;
  endfunction

  // Expected result is {cout, s}
  function automatic int sum_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/rca_bist_gold.sv
// rtl/rca_bist_gold.sv - combinational golden adder: expected {cout, s} for a vector index
module rca_bist_gold
  import rca_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [vec_w(WIDTH)-1:0] i_vec,
  output logic [sum_w(WIDTH)-1:0] o_sum
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;

  assign {w_a, w_b, w_cin} = i_vec;
  assign o_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

endmodule

// File: rtl/rca_bist.sv
// rtl/rca_bist.sv - exhaustive sweep driver/checker for a ripple-carry adder
module rca_bist
  import rca_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [WIDTH-1:0]        dut_a,
  output logic [WIDTH-1:0]        dut_b,
  output logic                    dut_cin,
  input  logic [WIDTH-1:0]        dut_s,
  input  logic                    dut_cout,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_count,
  output logic                    first_fail_valid,
  output logic [2*WIDTH:0]        first_fail_vec
);

  localparam int VW = vec_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           r_state;
  logic [VW-1:0]    r_v;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [VW-1:0]    r_ffvec;

  logic [SW-1:0]    w_exp;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] w_err_next;

  rca_bist_gold #(.WIDTH(WIDTH)) u_gold (
    .i_vec (r_v),
    .o_sum (w_exp)
  );

  assign w_mismatch = ({dut_cout, dut_s} != w_exp);
  assign w_last     = &r_v;
  // Counter sticks at all-ones so a saturated count can never read as a pass
  assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_v     <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_v     <= '0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          {r_a, r_b, r_cin} <= r_v;
          if (SETTLE == 0) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt   <= SETTLE_LD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_v;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_v     <= r_v + 1'b1;
            r_state <= ST_APPLY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_a            = r_a;
  assign dut_b            = r_b;
  assign dut_cin          = r_cin;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_rca_bist.sv
// tb/tb_rca_bist.sv - directed self-checking bench for rca_bist with a behavioural RCA
module tb_rca_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;

  logic [3:0]  dut_a, dut_b, dut_s;
  logic        dut_cin, dut_cout;
  logic        busy, done, pass, ffv;
  logic [15:0] err_count;
  logic [8:0]  ffvec;

  logic [3:0]  a4, b4, s4;
  logic        cin4, cout4;
  logic        busy4, done4, pass4, ffv4;
  logic [3:0]  err4;
  logic [8:0]  ffvec4;

  int          fault = 0;
  int          checks = 0;
  int          failures = 0;
  int          n;
  logic        busy_acc, done_acc;

  logic [4:0]  w_true, w_true4;

  always #5 clk = ~clk;

  // Behavioural RCA with selectable stuck-at faults
  assign w_true = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0, dut_cin};
  always_comb begin
    dut_s    = w_true[3:0];
    dut_cout = w_true[4];
    if (fault == 1) dut_s[0] = 1'b0;
    if (fault == 2) dut_cout = 1'b0;
  end

  // Second RCA is permanently s[0] stuck-at-0, checked by the narrow-counter instance
  assign w_true4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
  assign s4      = {w_true4[3:1], 1'b0};
  assign cout4   = w_true4[4];

  rca_bist u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_cin          (dut_cin),
    .dut_s            (dut_s),
    .dut_cout         (dut_cout),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (ffv),
    .first_fail_vec   (ffvec)
  );

  rca_bist #(.ERR_W(4)) u_dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_a            (a4),
    .dut_b            (b4),
    .dut_cin          (cin4),
    .dut_s            (s4),
    .dut_cout         (cout4),
    .busy             (busy4),
    .done             (done4),
    .pass             (pass4),
    .err_count        (err4),
    .first_fail_valid (ffv4),
    .first_fail_vec   (ffvec4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept a start, optionally re-pulse start pulse_at cycles later, count cycles to done
  task automatic run_sweep(input int pulse_at, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_acc = busy;
    done_acc = done;
    cycles   = 0;
    while (cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
      start = (cycles == pulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_dut_cin", dut_cin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ffv", ffv, 0);
    check("rst_ffvec", ffvec, 0);
    rst_n = 1'b1;

    fault = 0;
    run_sweep(-1, n);
    check("good_busy_at_accept", busy_acc, 1);
    check("good_cycles", n, 1536);
    check("good_done", done, 1);
    check("good_busy", busy, 0);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_ffv", ffv, 0);
    check("good_hold_a", dut_a, 15);
    check("good_hold_b", dut_b, 15);
    check("good_hold_cin", dut_cin, 1);
    check("sat_done", done4, 1);
    check("sat_err", err4, 15);
    check("sat_pass", pass4, 0);
    check("sat_ffvec", ffvec4, 1);

    fault = 1;
    run_sweep(-1, n);
    check("s0_done_drops", done_acc, 0);
    check("s0_cycles", n, 1536);
    check("s0_err", err_count, 256);
    check("s0_ffv", ffv, 1);
    check("s0_ffvec", ffvec, 1);
    check("s0_pass", pass, 0);

    fault = 2;
    run_sweep(-1, n);
    check("cout_err", err_count, 256);
    check("cout_ffvec", ffvec, 31);
    check("cout_pass", pass, 0);

    fault = 0;
    run_sweep(50, n);
    check("repulse_cycles", n, 1536);
    check("repulse_pass", pass, 1);
    check("repulse_err", err_count, 0);
    check("repulse_ffv", ffv, 0);

    run_sweep(-1, n);
    check("rerun_cycles", n, 1536);
    check("rerun_pass", pass, 1);
    check("rerun_err", err_count, 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pass", pass, 0);
    check("arst_dut_a", dut_a, 0);
    check("arst_dut_b", dut_b, 0);
    check("arst_dut_cin", dut_cin, 0);
    check("arst_err", err_count, 0);
    check("arst_ffvec", ffvec, 0);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    run_sweep(-1, n);
    check("post_rst_cycles", n, 1536);
    check("post_rst_pass", pass, 1);
    check("post_rst_err", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
